// File: rtl/wt_be_split_pkg.sv
// Shared types and helpers for the write-through byte-enable store splitter.
package wt_be_split_pkg;

    localparam int unsigned MEM_TID_WIDTH = 2;
    localparam int unsigned MAX_BE_WIDTH  = 64;

    typedef enum logic {
        IDLE,
        EMIT
    } wt_be_state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  size;
        logic        last;
    } wt_be_beat_t;

    typedef struct packed {
        logic [5:0] off;
        logic [2:0] size;
    } wt_be_sel_t;

    // Lowest set byte lane, then the widest naturally aligned fully enabled run
    // starting there, capped at max_bytes.
    function automatic wt_be_sel_t be_to_beat(input logic [63:0] be, input int unsigned max_bytes);
        wt_be_sel_t  r;
        logic        found;
        logic        run;
        int unsigned o;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_BE_WIDTH; i++) begin
            if (!found && be[i]) begin
                r.off = 6'(i);
                found = 1'b1;
            end
        end
        o = 32'(r.off);
        for (int unsigned k = 1; k <= 6; k++) begin
            if (((32'd1 << k) <= max_bytes) && ((o % (32'd1 << k)) == 0)) begin
                run = 1'b1;
                for (int unsigned j = 0; j < MAX_BE_WIDTH; j++) begin
                    if (j < (32'd1 << k)) begin
                        if ((o + j) >= MAX_BE_WIDTH) run = 1'b0;
                        else if (!be[6'(o + j)]) run = 1'b0;
                    end
                end
                if (run) r.size = 3'(k);
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] swendian64(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i*8 +: 8] = d[(7-i)*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wt_be_beat_sel.sv
// Combinational beat picker: lowest enabled lane, widest aligned run, and the
// byte enables left over once that beat is sent.
module wt_be_beat_sel
    import wt_be_split_pkg::*;
#(
    parameter int unsigned BeWidth  = 8,
    parameter int unsigned MaxBytes = 8
) (
    input  logic [BeWidth-1:0] be_i,
    output logic [5:0]         o_o,
    output logic [2:0]         k_o,
    output logic [BeWidth-1:0] next_be_o
);

    wt_be_sel_t  sel;
    int unsigned lo;
    int unsigned hi;

    always_comb begin
        sel       = be_to_beat(64'(be_i), MaxBytes);
        lo        = 32'(sel.off);
        hi        = lo + (32'd1 << sel.size);
        next_be_o = be_i;
        for (int unsigned i = 0; i < BeWidth; i++) begin
            if (i >= lo && i < hi) next_be_o[i] = 1'b0;
        end
        o_o = sel.off;
        k_o = sel.size;
    end

endmodule

// File: rtl/wt_be_split.sv
// Byte-enable store splitter: turns one masked write into a run of naturally
// aligned power-of-two beats for the L1.5/NoC adapter.
module wt_be_split
    import wt_be_split_pkg::*;
#(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned IdWidth    = MEM_TID_WIDTH,
    parameter int unsigned MaxBytes   = 8,
    parameter bit          SwapEndian = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [DataWidth-1:0]   req_data_i,
    input  logic [DataWidth/8-1:0] req_be_i,
    input  logic [IdWidth-1:0]     req_id_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [AddrWidth-1:0]   out_addr_o,
    output logic [DataWidth-1:0]   out_data_o,
    output logic [2:0]             out_size_o,
    output logic [IdWidth-1:0]     out_id_o,
    output logic                   out_last_o,
    output logic                   busy_o
);

    localparam int unsigned BeWidth = DataWidth / 8;

    wt_be_state_e           state_q;
    logic [AddrWidth-1:0]   base_q;
    logic [DataWidth-1:0]   data_q;
    logic [BeWidth-1:0]     be_q;
    logic [IdWidth-1:0]     id_q;

    logic [5:0]             sel_o;
    logic [2:0]             sel_k;
    logic [BeWidth-1:0]     next_be;
    logic                   out_fire;
    logic                   req_fire;
    wt_be_beat_t            beat;

    wt_be_beat_sel #(
        .BeWidth  (BeWidth),
        .MaxBytes (MaxBytes)
    ) i_beat_sel (
        .be_i      (be_q),
        .o_o       (sel_o),
        .k_o       (sel_k),
        .next_be_o (next_be)
    );

    always_comb begin
        beat.addr = 64'(base_q) + 64'(sel_o);
        beat.size = sel_k;
        beat.last = (state_q == EMIT) && (next_be == '0);
    end

    assign out_valid_o = (state_q == EMIT);
    assign busy_o      = (state_q == EMIT);
    assign out_addr_o  = beat.addr[AddrWidth-1:0];
    assign out_size_o  = beat.size;
    assign out_last_o  = beat.last;
    assign out_id_o    = id_q;
    assign out_fire    = out_valid_o && out_ready_i;
    // Accepting during the final beat lets the next request load with no bubble.
    assign req_ready_o = (state_q == IDLE) || (out_fire && out_last_o);
    assign req_fire    = req_valid_i && req_ready_o;

    for (genvar w = 0; w < DataWidth / 64; w++) begin : g_swap
        assign out_data_o[w*64 +: 64] = SwapEndian ? swendian64(data_q[w*64 +: 64])
                                                   : data_q[w*64 +: 64];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            base_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            id_q    <= '0;
        end else if (req_fire) begin
            base_q  <= req_addr_i & ~AddrWidth'(BeWidth - 1);
            data_q  <= req_data_i;
            be_q    <= req_be_i;
            id_q    <= req_id_i;
            state_q <= (req_be_i != '0) ? EMIT : IDLE;
        end else if (out_fire) begin
            be_q <= next_be;
            if (out_last_o) state_q <= IDLE;
        end
    end

endmodule
